cfi_shadow_stack_ctrl: RTL

Controller that executes shadow-stack CFI operations (sspush, sspopchk, sspop, ssprr) issued by the execute stage. It keeps the top DEPTH return addresses in an on-chip buffer and maintains the shadow stack pointer (SSP). When the buffer overflows, the oldest entry is spilled to memory. When it underflows, an entry is filled back from memory over a req/gnt/rvalid port. Pop-check mismatches, stack underflow and stack overflow are reported as CFI faults.

---
 rtl/cfi_shadow_stack_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cfi_shadow_stack_ctrl.sv
// cfi_shadow_stack_ctrl: shadow-stack CFI op controller with an on-chip top-of-stack buffer
// that spills its oldest entry to memory on overflow and fills from memory on underflow.
module cfi_shadow_stack_ctrl #(
  parameter int XLEN = 64,
  parameter int DEPTH = 8,
  parameter logic [XLEN-1:0] SSP_BASE = 64'h8000_1000,
  parameter logic [XLEN-1:0] SSP_LIMIT = 64'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_data_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            cfi_fault_o,
  output logic [XLEN-1:0] ssp_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] W = XLEN'(XLEN / 8);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [2:0] IDLE = 3'd0, SPILL = 3'd1, FILL_REQ = 3'd2, FILL_WAIT = 3'd3, RESP = 3'd4;
  localparam logic [1:0] PUSH = 2'b00, POPCHK = 2'b01, POP = 2'b10, RDSSP = 2'b11;

  logic [2:0]      state;
  logic [XLEN-1:0] ssp, rsp_q, data_q;
  logic [1:0]      op_q;
  logic            fault_q;
  logic [AW:0]     cnt;
  logic [AW-1:0]   top, oldest;
  logic [XLEN-1:0] stk [DEPTH];
  logic            accept, at_limit, push_wr;
  logic [XLEN-1:0] ssp_dn, ssp_up, top_val, push_val;

  // top indexes the entry at SSP; the entry count-1 slots above it is the oldest
  assign accept = op_valid_i && state == IDLE;
  assign at_limit = ssp < SSP_LIMIT + W;
  assign ssp_dn = ssp - W;
  assign ssp_up = ssp + W;
  assign oldest = top + cnt[AW-1:0] - AW'(1);
  assign top_val = stk[top];
  assign push_wr = (accept && op_i == PUSH && !at_limit && cnt != FULL) || (state == SPILL && mem_gnt_i);
  assign push_val = state == SPILL ? data_q : op_data_i;

  assign op_ready_o = state == IDLE;
  assign rsp_valid_o = state == RESP;
  assign rsp_data_o = rsp_valid_o ? rsp_q : '0;
  assign cfi_fault_o = rsp_valid_o && fault_q;
  assign ssp_o = ssp;
  assign mem_req_o = state == SPILL || state == FILL_REQ;
  assign mem_we_o = state == SPILL;
  assign mem_addr_o = state == SPILL ? ssp + XLEN'(DEPTH - 1) * W : state == FILL_REQ ? ssp : '0;
  assign mem_wdata_o = mem_we_o ? stk[oldest] : '0;

  always_ff @(posedge clk_i)
    if (push_wr) stk[top - AW'(1)] <= push_val;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ssp <= SSP_BASE;
      cnt <= '0;
      top <= '0;
      op_q <= PUSH;
      data_q <= '0;
      rsp_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (op_valid_i) begin
          op_q <= op_i;
          data_q <= op_data_i;
          fault_q <= 1'b0;
          rsp_q <= ssp;
          state <= RESP;
          if (op_i == PUSH) begin
            if (at_limit) fault_q <= 1'b1;
            else if (cnt == FULL) state <= SPILL;
            else begin
              ssp <= ssp_dn;
              top <= top - AW'(1);
              cnt <= cnt + ONE;
              rsp_q <= ssp_dn;
            end
          end else if (op_i != RDSSP) begin
            if (ssp == SSP_BASE) begin
              fault_q <= 1'b1;
              rsp_q <= op_i == POP ? '0 : ssp;
            end else if (cnt != '0) begin
              ssp <= ssp_up;
              top <= top + AW'(1);
              cnt <= cnt - ONE;
              rsp_q <= op_i == POP ? top_val : ssp_up;
              fault_q <= op_i == POPCHK && top_val != op_data_i;
            end else state <= FILL_REQ;
          end
        end
        // the spilled slot is reused for the new top, so count stays at DEPTH
        SPILL: if (mem_gnt_i) begin
          ssp <= ssp_dn;
          top <= top - AW'(1);
          rsp_q <= ssp_dn;
          state <= RESP;
        end
        FILL_REQ: if (mem_gnt_i) state <= FILL_WAIT;
        FILL_WAIT: if (mem_rvalid_i) begin
          ssp <= ssp_up;
          rsp_q <= op_q == POP ? mem_rdata_i : ssp_up;
          fault_q <= op_q == POPCHK && mem_rdata_i != data_q;
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
